// File: rtl/fft_lane_fifo_pkg.sv
// fft_lane_fifo_pkg
//   Shared types and default sizing for the multi-lane complex FIFO that sits
//   between FFT butterfly stages.
//   WIDTH        : signed bits per real/imag component
//   sample_t     : one signed component
//   lane_vec_t   : one entry's worth of components at the default lane count
package fft_lane_fifo_pkg;

  localparam int WIDTH     = 9;
  localparam int DEF_LANES = 16;
  localparam int DEF_DEPTH = 16;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef sample_t [DEF_LANES-1:0] lane_vec_t;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fft_lane_fifo_if.sv
// fft_lane_fifo_if
//   Valid/ready handshake bundle for both sides of the lane FIFO.
//   wr_valid/wr_ready/wr_real/wr_imag : producer side (entry offered / accepted)
//   rd_valid/rd_ready/rd_real/rd_imag : consumer side (FWFT head entry)
//   master : the producer/consumer environment
//   slave  : the FIFO itself
interface fft_lane_fifo_if
  import fft_lane_fifo_pkg::*;
#(
  parameter int WIDTH = fft_lane_fifo_pkg::WIDTH,
  parameter int LANES = DEF_LANES
);

  logic                        wr_valid;
  logic                        wr_ready;
  logic [LANES-1:0][WIDTH-1:0] wr_real;
  logic [LANES-1:0][WIDTH-1:0] wr_imag;

  logic                        rd_valid;
  logic                        rd_ready;
  logic [LANES-1:0][WIDTH-1:0] rd_real;
  logic [LANES-1:0][WIDTH-1:0] rd_imag;

  modport master (
    output wr_valid, wr_real, wr_imag, rd_ready,
    input  wr_ready, rd_valid, rd_real, rd_imag
  );

  modport slave (
    input  wr_valid, wr_real, wr_imag, rd_ready,
    output wr_ready, rd_valid, rd_real, rd_imag
  );

endinterface

// File: rtl/fft_lane_fifo_ctrl.sv
// fft_fifo_ctrl
//   Pointer, occupancy and flag logic for the lane FIFO. Storage lives in the
//   top level; this block only decides when an entry moves and where.
//   clk_i, rst_i (sync, active-high), flush_i (sync clear)
//   wr_valid_i, rd_ready_i     : handshake requests
//   wr_ready_o, rd_valid_o     : handshake grants, from registered count only
//   push_o, pop_o              : qualified transfers this cycle
//   wr_ptr_o, rd_ptr_o         : storage indices
//   count_o, full_o, empty_o, almost_full_o : occupancy status
module fft_fifo_ctrl
  import fft_lane_fifo_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = count_bits(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_valid_i,
  input  logic          rd_ready_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  output logic          push_o,
  output logic          pop_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, xfer_en;

  // Flags decode straight from the registered count, so wr_ready never
  // depends on rd_ready and a full FIFO refuses writes even while popping.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign xfer_en = ~(rst_i | flush_i);

  assign push_o = wr_valid_i & ~full & xfer_en;
  assign pop_o  = rd_ready_i & ~empty & xfer_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_o) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_o)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_o, pop_o})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ready_o    = ~full;
  assign rd_valid_o    = ~empty;
  assign wr_ptr_o      = wr_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
  assign almost_full_o = (count_q >= CW'(AF_LEVEL));

endmodule

// File: rtl/fft_lane_fifo.sv
// fft_lane_fifo
//   Parametrised multi-lane complex FIFO between FFT butterfly stages.
//   Each entry holds LANES complex samples; read side is first-word-fall-
//   through with zeroed data while empty.
//   clk_i          : clock, rising edge
//   rst_i          : synchronous reset, active-high
//   flush_i        : synchronous content clear
//   bus            : write/read valid/ready handshake and lane data
//   count_o        : entries stored
//   full_o/empty_o : count == DEPTH / count == 0
//   almost_full_o  : count >= AF_LEVEL
module fft_lane_fifo
  import fft_lane_fifo_pkg::*;
#(
  parameter  int WIDTH    = fft_lane_fifo_pkg::WIDTH,
  parameter  int LANES    = DEF_LANES,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = count_bits(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  fft_lane_fifo_if.slave bus,
  output logic [CW-1:0]  count_o,
  output logic           full_o,
  output logic           empty_o,
  output logic           almost_full_o
);

  logic          push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Storage is deliberately not reset; the pointers make stale entries
  // unreachable after reset or flush.
  logic [LANES-1:0][WIDTH-1:0] mem_real_q [DEPTH];
  logic [LANES-1:0][WIDTH-1:0] mem_imag_q [DEPTH];

  fft_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctrl (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .wr_valid_i    (bus.wr_valid),
    .rd_ready_i    (bus.rd_ready),
    .wr_ready_o    (bus.wr_ready),
    .rd_valid_o    (bus.rd_valid),
    .push_o        (push),
    .pop_o         (pop),
    .wr_ptr_o      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .almost_full_o (almost_full_o)
  );

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_real_q[wr_ptr] <= bus.wr_real;
      mem_imag_q[wr_ptr] <= bus.wr_imag;
    end
  end

  // Pop only advances rd_ptr in the controller; the head is read in place.
  logic unused_pop;
  assign unused_pop = pop;

  assign bus.rd_real = empty_o ? '0 : mem_real_q[rd_ptr];
  assign bus.rd_imag = empty_o ? '0 : mem_imag_q[rd_ptr];

endmodule
